// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer between the UART core and the host register interface.
// Define RX_TIMEOUT_EN to build the character-timeout interrupt.
module uart_rx_fifo #(
    parameter int DEPTH         = 16,
    parameter int TIMEOUT_TICKS = 64,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_valid,
    input  logic          wr_error,
    input  logic          baud16_en,
    input  logic          rd_en,
    input  logic          flush,
    input  logic          ovr_clr,
    input  logic [AW:0]   thresh,
    output logic [7:0]    rd_data,
    output logic          rd_error,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overrun,
    output logic          thresh_irq,
    output logic          timeout_irq
);

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } entry_t;

    localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level_q;
    logic          do_wr, do_rd, ovr_set;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_MAX);
    assign level   = level_q;

    // A pop frees the slot the same cycle, so a write into a full FIFO
    // with rd_en asserted is accepted rather than counted as an overrun.
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_valid && (!full || rd_en);
    assign ovr_set = wr_valid && full && !rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            overrun <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
            if (ovr_set)      overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr] <= entry_t'{err: wr_error, data: wr_data};
    end

    assign head     = mem[rd_ptr];
    assign rd_data  = empty ? 8'h00 : head.data;
    assign rd_error = empty ? 1'b0  : head.err;

    // level never exceeds DEPTH, so a thresh above DEPTH can never fire.
    assign thresh_irq = (thresh != '0) && (level_q >= thresh);

`ifdef RX_TIMEOUT_EN
    localparam int            CW      = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_TICKS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] to_cnt, to_cnt_nxt;
    logic          to_irq, activity;

    assign activity = flush || do_wr || do_rd;

    always_comb begin
        to_cnt_nxt = to_cnt;
        if (activity || empty)
            to_cnt_nxt = '0;
        else if (baud16_en && to_cnt != CNT_MAX)
            to_cnt_nxt = to_cnt + CNT_ONE;
    end

    // The flag rises on the same edge the counter reaches its limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            to_irq <= 1'b0;
        end else begin
            to_cnt <= to_cnt_nxt;
            if (activity)                   to_irq <= 1'b0;
            else if (to_cnt_nxt == CNT_MAX) to_irq <= 1'b1;
        end
    end

    assign timeout_irq = to_irq;
`else
    logic unused_baud;
    assign unused_baud = baud16_en;
    assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo; a byte queue models expected FIFO contents.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef RX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  wr_data;
    logic        wr_valid, wr_error, baud16_en, rd_en, flush, ovr_clr;
    logic [AW:0] thresh;
    logic [7:0]  rd_data;
    logic        rd_error, empty, full, overrun, thresh_irq, timeout_irq;
    logic [AW:0] level;

    int tests = 0;
    int fails = 0;
    logic [8:0] sb [$];

    uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_TICKS(64)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_error(wr_error), .baud16_en(baud16_en), .rd_en(rd_en),
        .flush(flush), .ovr_clr(ovr_clr), .thresh(thresh),
        .rd_data(rd_data), .rd_error(rd_error), .empty(empty), .full(full),
        .level(level), .overrun(overrun), .thresh_irq(thresh_irq),
        .timeout_irq(timeout_irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic e);
        wr_data = d; wr_error = e; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0; wr_error = 1'b0;
        if (sb.size() < DEPTH) sb.push_back({e, d});
    endtask

    task automatic pop(input string tag);
        logic [8:0] exp;
        if (sb.size() == 0) begin
            chk({tag, "_sb_underrun"}, 32'(empty), 32'd0);
            return;
        end
        exp = sb.pop_front();
        chk({tag, "_data"}, 32'(rd_data), 32'(exp[7:0]));
        chk({tag, "_err"},  32'(rd_error), 32'(exp[8]));
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    // Write and pop in one cycle; an empty FIFO only takes the write.
    task automatic push_pop(input string tag, input logic [7:0] d);
        logic [8:0] exp;
        if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk({tag, "_head"}, 32'(rd_data), 32'(exp[7:0]));
        end
        wr_data = d; wr_error = 1'b0; wr_valid = 1'b1; rd_en = 1'b1;
        step();
        wr_valid = 1'b0; rd_en = 1'b0;
        sb.push_back({1'b0, d});
    endtask

    task automatic tick();
        baud16_en = 1'b1; step();
        baud16_en = 1'b0; step();
    endtask

    initial begin
        rst = 1'b1; wr_data = '0; wr_valid = 0; wr_error = 0; baud16_en = 0;
        rd_en = 0; flush = 0; ovr_clr = 0; thresh = '0;
        step(); step();
        rst = 1'b0;
        step();

        // reset state
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_rdata", 32'(rd_data), 32'd0);
        chk("rst_tirq", 32'(thresh_irq), 32'd0);
        chk("rst_toirq", 32'(timeout_irq), 32'd0);

        // single byte, FWFT
        push(8'h41, 1'b0);
        chk("one_empty", 32'(empty), 32'd0);
        chk("one_level", 32'(level), 32'd1);
        pop("one");
        chk("one_empty_after", 32'(empty), 32'd1);
        chk("one_rdata_zero", 32'(rd_data), 32'd0);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("underflow_level", 32'(level), 32'd0);

        // write+pop on empty: write only
        push_pop("wp_empty", 8'h3C);
        chk("wp_empty_level", 32'(level), 32'd1);
        pop("wp_empty_drain");

        // fill, overrun, drain in order
        for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd16);
        chk("fill_ovr0", 32'(overrun), 32'd0);
        push(8'hAA, 1'b0);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_level", 32'(level), 32'd16);
        for (int i = 0; i < DEPTH; i++) pop("drain16");
        chk("drain_empty", 32'(empty), 32'd1);
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);

        // full + simultaneous write/pop; thresh boundaries at DEPTH
        for (int i = 0; i < DEPTH; i++) push(8'h20 + 8'(i), 1'b0);
        thresh = 5'd17; #1;
        chk("thresh_gt_depth", 32'(thresh_irq), 32'd0);
        thresh = 5'd16; #1;
        chk("thresh_eq_depth", 32'(thresh_irq), 32'd1);
        thresh = '0; #1;
        chk("thresh_zero", 32'(thresh_irq), 32'd0);
        push_pop("wp_full", 8'h55);
        chk("wp_full_level", 32'(level), 32'd16);
        chk("wp_full_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < DEPTH; i++) pop("wp_drain");
        chk("wp_drain_empty", 32'(empty), 32'd1);

        // threshold interrupt and error flag
        thresh = 5'd4;
        for (int i = 0; i < 3; i++) push(8'h60 + 8'(i), 1'b0);
        chk("thr_3", 32'(thresh_irq), 32'd0);
        push(8'h63, 1'b0);
        chk("thr_4", 32'(thresh_irq), 32'd1);
        pop("thr_pop");
        chk("thr_pop_irq", 32'(thresh_irq), 32'd0);
        push(8'hE7, 1'b1);
        while (sb.size() != 0) pop("err_drain");
        thresh = '0;

        // flush with concurrent write while overrun is set
        for (int i = 0; i <= DEPTH; i++) push(8'h80 + 8'(i), 1'b0);
        for (int i = 0; i < DEPTH - 5; i++) pop("pre_flush");
        chk("pre_flush_level", 32'(level), 32'd5);
        chk("pre_flush_ovr", 32'(overrun), 32'd1);
        flush = 1'b1; wr_valid = 1'b1; wr_data = 8'hBB;
        step();
        flush = 1'b0; wr_valid = 1'b0;
        sb.delete();
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_ovr", 32'(overrun), 32'd0);
        push(8'h77, 1'b0);
        pop("post_flush");

        // asynchronous reset mid-sequence
        for (int i = 0; i <= DEPTH; i++) push(8'hC0 + 8'(i), 1'b0);
        @(negedge clk);
        rst = 1'b1; #2;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_ovr", 32'(overrun), 32'd0);
        sb.delete();
        step();
        rst = 1'b0;
        step();

        // character timeout
        push(8'h99, 1'b0);
        for (int i = 0; i < 63; i++) tick();
        chk("to_63", 32'(timeout_irq), 32'd0);
        tick();
        chk("to_64", 32'(timeout_irq), 32'(TO_EN));
        tick();
        chk("to_sticky", 32'(timeout_irq), 32'(TO_EN));
        pop("to_pop");
        chk("to_pop_clear", 32'(timeout_irq), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
